// File: rtl/lfm_period_meter_if.sv
// Sample stream in, period/sweep/lock status out, between a sample source and the meter.
// Latency: n/a (wiring only).
// Backpressure: none; din_valid qualifies each sample and there is no ready.
interface lfm_period_meter_if #(
  parameter int IN_WIDTH  = 16,
  parameter int CNT_WIDTH = 24
);
  logic [IN_WIDTH-1:0]  din;
  logic                 din_valid;
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 sweep_up;
  logic                 sweep_down;
  logic [15:0]          cycles;
  logic                 locked;
  logic                 timeout;

  // Sample source: drives samples, observes measurements.
  modport master (
    output din, din_valid,
    input  period, period_valid, sweep_up, sweep_down, cycles, locked, timeout
  );

  // Meter: consumes samples, drives measurements.
  modport slave (
    input  din, din_valid,
    output period, period_valid, sweep_up, sweep_down, cycles, locked, timeout
  );
endinterface

// File: rtl/lfm_period_meter.sv
// Measures sine/chirp period in samples via hysteretic rising mid-level crossings.
// Latency: 1 cycle from the crossing sample to period_valid / timeout.
// Backpressure: none; every din_valid sample is consumed, idle cycles freeze all state.
module lfm_period_meter #(
  parameter int IN_WIDTH    = 16,
  parameter int MID         = 32768,
  parameter int HYST        = 256,
  parameter int CNT_WIDTH   = 24,
  parameter int MAX_PERIOD  = 1000000,
  parameter int LOCK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lfm_period_meter_if.slave  bus
);

  localparam logic [IN_WIDTH-1:0]  LO_TH = IN_WIDTH'(MID - HYST);
  localparam logic [IN_WIDTH-1:0]  HI_TH = IN_WIDTH'(MID + HYST);
  localparam logic [CNT_WIDTH-1:0] MAX_P = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [15:0]          LOCK_N = 16'(LOCK_CYCLES);

  typedef enum logic [1:0] {IDLE, PRE, HI, LO} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] prev_q, prev_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 pv_q, pv_d;
  logic                 up_q, up_d;
  logic                 down_q, down_d;
  logic [15:0]          cycles_q, cycles_d;
  logic                 locked_q, locked_d;
  logic                 to_q, to_d;

  logic                 is_low, is_high;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign is_low  = (bus.din <  LO_TH);
  assign is_high = (bus.din >= HI_TH);
  assign cnt_inc = cnt_q + 1'b1;

  // State and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      cycles_q <= '0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      up_q     <= up_d;
      down_q   <= down_d;
      cycles_q <= cycles_d;
      locked_q <= locked_d;
      to_q     <= to_d;
    end
  end

  // Crossing FSM: next state, counter, period/sweep/lock updates, timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    period_d = period_q;
    pv_d     = 1'b0;
    up_d     = up_q;
    down_d   = down_q;
    cycles_d = cycles_q;
    locked_d = locked_q;
    to_d     = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        IDLE: if (is_low) state_d = PRE;
        PRE: begin
          // Reference crossing: starts counting, produces no period.
          if (is_high) begin
            state_d = HI;
            cnt_d   = '0;
          end
        end
        HI, LO: begin
          if (state_q == LO && is_high) begin
            // Rising crossing; the crossing sample closes the period, so it wins over timeout.
            state_d  = HI;
            cnt_d    = '0;
            period_d = cnt_inc;
            pv_d     = 1'b1;
            // prev_q == 0 marks the first period since IDLE: no direction yet.
            up_d     = (prev_q != '0) && (cnt_inc < prev_q);
            down_d   = (prev_q != '0) && (cnt_inc > prev_q);
            prev_d   = cnt_inc;
            if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
            if (cycles_d >= LOCK_N) locked_d = 1'b1;
          end else if (cnt_inc == MAX_P) begin
            // Lost the signal: restart acquisition, keep the last reported period/flags.
            to_d     = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            cycles_d = '0;
            locked_d = 1'b0;
            prev_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (state_q == HI && is_low) state_d = LO;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.sweep_up     = up_q;
  assign bus.sweep_down   = down_q;
  assign bus.cycles       = cycles_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = to_q;

endmodule

// File: tb/tb_lfm_period_meter.sv
// Directed bench for lfm_period_meter: table of per-period records plus corner sequences.
// Latency: outputs checked #1 after the edge that clocks each sample.
// Backpressure: none; gaps are exercised with din_valid=0 cycles.
module tb_lfm_period_meter;

  logic clk;
  logic rst_n;

  lfm_period_meter_if #(.IN_WIDTH(16), .CNT_WIDTH(24)) bus ();

  lfm_period_meter #(
    .IN_WIDTH(16), .MID(32768), .HYST(256), .CNT_WIDTH(24),
    .MAX_PERIOD(64), .LOCK_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = n_lo low samples, n_band band samples, n_hi high samples.
  // The expected fields apply right after the first high sample (the rising edge).
  typedef struct {
    bit rst;
    bit gaps;
    int n_lo;
    int n_band;
    int n_hi;
    bit pv;
    int per;
    bit up;
    bit dn;
    int cyc;
    bit lk;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input bit rst, input bit gaps, input int n_lo, input int n_band,
                              input int n_hi, input bit pv, input int per, input bit up,
                              input bit dn, input int cyc, input bit lk);
    vec_t v;
    v.rst = rst; v.gaps = gaps; v.n_lo = n_lo; v.n_band = n_band; v.n_hi = n_hi;
    v.pv = pv; v.per = per; v.up = up; v.dn = dn; v.cyc = cyc; v.lk = lk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Valid sample, optionally preceded by an ignored opposite-level idle cycle.
  task automatic samp(input logic [15:0] d, input bit gaps, input string tag);
    if (gaps) begin
      step(~d, 1'b0);
      chk({tag, " gap pv"}, 32'(bus.period_valid), 0);
      chk({tag, " gap to"}, 32'(bus.timeout), 0);
    end
    step(d, 1'b1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.din       = 16'h8000;
    rst_n         = 1'b0;
    #1;
    chk({tag, " rst period"}, 32'(bus.period), 0);
    chk({tag, " rst pv"},     32'(bus.period_valid), 0);
    chk({tag, " rst up"},     32'(bus.sweep_up), 0);
    chk({tag, " rst dn"},     32'(bus.sweep_down), 0);
    chk({tag, " rst cyc"},    32'(bus.cycles), 0);
    chk({tag, " rst lk"},     32'(bus.locked), 0);
    chk({tag, " rst to"},     32'(bus.timeout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_rec(input vec_t r, input string tag);
    for (int k = 0; k < r.n_lo; k++) begin
      samp(16'h0000, r.gaps, tag);
      chk({tag, " lo pv"}, 32'(bus.period_valid), 0);
      chk({tag, " lo to"}, 32'(bus.timeout), 0);
    end
    for (int k = 0; k < r.n_band; k++) begin
      samp(k[0] ? 16'h80C8 : 16'h7F38, r.gaps, tag);
      chk({tag, " band pv"}, 32'(bus.period_valid), 0);
    end
    samp(16'hFFFF, r.gaps, tag);
    chk({tag, " edge pv"}, 32'(bus.period_valid), 32'(r.pv));
    if (r.pv) begin
      chk({tag, " period"}, 32'(bus.period), 32'(r.per));
      chk({tag, " up"},     32'(bus.sweep_up), 32'(r.up));
      chk({tag, " dn"},     32'(bus.sweep_down), 32'(r.dn));
    end
    chk({tag, " cycles"}, 32'(bus.cycles), 32'(r.cyc));
    chk({tag, " locked"}, 32'(bus.locked), 32'(r.lk));
    chk({tag, " edge to"}, 32'(bus.timeout), 0);
    for (int k = 1; k < r.n_hi; k++) begin
      samp(16'hFFFF, r.gaps, tag);
      chk({tag, " hi pv"}, 32'(bus.period_valid), 0);
      chk({tag, " hi to"}, 32'(bus.timeout), 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.din       = 16'h8000;
    bus.din_valid = 1'b0;

    // Square wave 5/5: reference edge, then period 10, lock on the 4th period.
    tbl.push_back(mk(1, 0, 5, 0, 5, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 4, 1));
    tbl.push_back(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 5, 1));
    // Same wave with 3 band samples before each rising edge: period 13.
    tbl.push_back(mk(1, 0, 5, 3, 5, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 3, 5, 1, 13, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 5, 3, 5, 1, 13, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 5, 3, 5, 1, 13, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 5, 3, 5, 1, 13, 0, 0, 4, 1));
    // Shrinking periods 20,18,16,14: frequency rising.
    tbl.push_back(mk(1, 0, 10, 0, 10, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10, 0,  9, 1, 20, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  9, 0,  8, 1, 18, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0,  8, 0,  7, 1, 16, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0,  7, 0,  7, 1, 14, 1, 0, 4, 1));
    // Growing periods 14,16,18,20: frequency falling.
    tbl.push_back(mk(1, 0,  7, 0,  7, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  7, 0,  8, 1, 14, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  8, 0,  9, 1, 16, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0,  9, 0, 10, 1, 18, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 10, 0, 10, 1, 20, 0, 1, 4, 1));
    // Square wave 5/5 with an idle cycle before every sample: still period 10.
    tbl.push_back(mk(1, 1, 5, 0, 5, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, 5, 1, 10, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 5, 0, 5, 1, 10, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 5, 0, 5, 1, 10, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 5, 0, 5, 1, 10, 0, 0, 4, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      run_rec(tbl[i], $sformatf("v%0d", i));
    end

    // Timeout: lock, then hold high until the 64th sample after the last edge.
    do_reset("to");
    for (int k = 0; k < 5; k++)
      run_rec(mk(0, 0, 5, 0, 5, k > 0, 10, 0, 0, k, k == 4), $sformatf("to_l%0d", k));
    for (int j = 5; j < 64; j++) begin
      step(16'hFFFF, 1'b1);
      chk($sformatf("to hold%0d", j), 32'(bus.timeout), 0);
    end
    step(16'hFFFF, 1'b1);
    chk("to pulse",  32'(bus.timeout), 1);
    chk("to locked", 32'(bus.locked), 0);
    chk("to cycles", 32'(bus.cycles), 0);
    chk("to period", 32'(bus.period), 10);
    chk("to pv",     32'(bus.period_valid), 0);
    step(16'hFFFF, 1'b0);
    chk("to drop",   32'(bus.timeout), 0);
    // Next rising edge is only a new reference; previous period was forgotten.
    run_rec(mk(0, 0, 5, 0, 5, 0, 0, 0, 0, 0, 0), "to_ref");
    run_rec(mk(0, 0, 3, 0, 32, 1, 8, 0, 0, 1, 0), "to_p8");
    // Edge landing exactly on the timeout sample: the period wins.
    run_rec(mk(0, 0, 32, 0, 1, 1, 64, 0, 1, 2, 0), "tie");

    // Reset mid-period after a measurement, then reacquire from scratch.
    do_reset("mr");
    run_rec(mk(0, 0, 5, 0, 5, 0, 0, 0, 0, 0, 0), "mr_ref");
    run_rec(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 1, 0), "mr_p");
    repeat (3) step(16'h0000, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr period", 32'(bus.period), 0);
    chk("mr cycles", 32'(bus.cycles), 0);
    chk("mr pv",     32'(bus.period_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_rec(mk(0, 0, 2, 0, 5, 0, 0, 0, 0, 0, 0), "mr_ref2");
    run_rec(mk(0, 0, 5, 0, 5, 1, 10, 0, 0, 1, 0), "mr_p2");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
